// File: rtl/ss_score_display_if.sv
// Bus for ss_score_display: load/busy handshake, display mode and segment outputs.
interface ss_score_display_if #(
    parameter int SCORE_W    = 7,
    parameter int NUM_DIGITS = 2
);
    logic [SCORE_W-1:0]      score_in;
    logic                    load;
    logic [1:0]              mode;
    logic                    busy;
    logic                    overflow;
    logic                    blink_phase;
    logic [8*NUM_DIGITS-1:0] seg_out;

    modport master (
        output score_in, load, mode,
        input  busy, overflow, blink_phase, seg_out
    );

    modport slave (
        input  score_in, load, mode,
        output busy, overflow, blink_phase, seg_out
    );
endinterface

// File: rtl/ss_score_display.sv
// Binary score -> NUM_DIGITS-digit 7-segment driver with sequential double-dabble
// conversion, saturation and static / blink / scan / blank display modes.
// Optional feature: define SS_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module ss_score_display #(
    parameter int SCORE_W    = 7,
    parameter int NUM_DIGITS = 2,
    parameter int BLINK_DIV  = 6_000_000
) (
    input  logic               hwclk,
    input  logic               reset,
    ss_score_display_if.slave  bus
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(SCORE_W) + 1;
    localparam int PW = $clog2(BLINK_DIV);
    localparam int XW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic longint unsigned max_val();
        longint unsigned v = 1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) v = v * 10;
        return v - 1;
    endfunction

    localparam longint unsigned MAXV = max_val();

    function automatic logic [7:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t                  state, nstate;
    logic [SCORE_W-1:0]      bin;
    logic [BW-1:0]           bcd, adj, disp;
    logic [CW-1:0]           step;
    logic                    ovf;
    logic [PW-1:0]           pcnt, pcnt_nxt;
    logic                    phase, phase_nxt, wrap;
    logic [XW-1:0]           scan, scan_nxt;
    logic [8*NUM_DIGITS-1:0] seg, seg_nxt;
    logic                    over;
    logic [SCORE_W-1:0]      sat_val;
    logic [NUM_DIGITS-1:0]   nz;
    logic [7:0]              digit;
    logic                    show;

    // FSM state register
    always_ff @(posedge hwclk) begin
        if (!reset) state <= S_IDLE;
        else        state <= nstate;
    end

    // FSM next state: accept in IDLE, SCORE_W shift steps, one copy cycle
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (bus.load) nstate = S_CONV;
            S_CONV:  if (step == CW'(SCORE_W - 1)) nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Saturation of the incoming score to the largest displayable value
    always_comb begin
        over    = 64'(bus.score_in) > MAXV;
        sat_val = over ? SCORE_W'(MAXV) : bus.score_in;
    end

    // Add-3 correction on every BCD digit that is 5 or more before the shift
    always_comb begin
        adj = bcd;
        for (int unsigned k = 0; k < NUM_DIGITS; k++)
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end

    // Conversion datapath and display register
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            bin  <= '0;
            bcd  <= '0;
            step <= '0;
            ovf  <= 1'b0;
            disp <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.load) begin
                    bin  <= sat_val;
                    ovf  <= over;
                    bcd  <= '0;
                    step <= '0;
                end
                S_CONV: begin
                    bcd  <= {adj[BW-2:0], bin[SCORE_W-1]};
                    bin  <= {bin[SCORE_W-2:0], 1'b0};
                    step <= step + CW'(1);
                end
                S_DONE:  disp <= bcd;
                default: ;
            endcase
        end
    end

    // Next phase counter, blink phase and scan index
    always_comb begin
        wrap      = (pcnt == PW'(BLINK_DIV - 1));
        pcnt_nxt  = wrap ? '0 : pcnt + PW'(1);
        phase_nxt = phase ^ wrap;
        if (bus.mode != 2'b10)                    scan_nxt = '0;
        else if (!wrap)                           scan_nxt = scan;
        else if (scan == XW'(NUM_DIGITS - 1))     scan_nxt = '0;
        else                                      scan_nxt = scan + XW'(1);
    end

    // Segment image built from the next phase/scan so output stays in step with them
    always_comb begin
        seg_nxt = '0;
        digit   = '0;
        show    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) nz[k] = (disp[4*k +: 4] != 4'd0);
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            digit = dec7(disp[4*k +: 4]);
`ifdef SS_LEADING_ZERO_BLANK_EN
            if (k != 0 && (nz >> k) == '0) digit = '0;
`endif
            case (bus.mode)
                2'b00:   show = 1'b1;
                2'b01:   show = phase_nxt;
                2'b10:   show = (scan_nxt == XW'(k));
                default: show = 1'b0;
            endcase
            seg_nxt[8*k +: 8] = show ? digit : 8'h00;
        end
    end

    // Phase counter, scan index and registered segment outputs
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            pcnt  <= '0;
            phase <= 1'b0;
            scan  <= '0;
            seg   <= '0;
        end else begin
            pcnt  <= pcnt_nxt;
            phase <= phase_nxt;
            scan  <= scan_nxt;
            seg   <= seg_nxt;
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.overflow    = ovf;
    assign bus.blink_phase = phase;
    assign bus.seg_out     = seg;
endmodule

// File: tb/tb_ss_score_display.sv
// Self-checking bench for ss_score_display: two instances (2 and 3 digits) share stimulus
// and are compared every cycle against an arithmetic timeline model, plus directed checks.
module tb_ss_score_display;
    localparam int SW = 7;
    localparam int BD = 4;
`ifdef SS_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic hwclk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 hwclk = ~hwclk;

    ss_score_display_if #(.SCORE_W(SW), .NUM_DIGITS(2)) bus2 ();
    ss_score_display_if #(.SCORE_W(SW), .NUM_DIGITS(3)) bus3 ();

    ss_score_display #(.SCORE_W(SW), .NUM_DIGITS(2), .BLINK_DIV(BD)) dut2 (
        .hwclk(hwclk), .reset(reset), .bus(bus2.slave));
    ss_score_display #(.SCORE_W(SW), .NUM_DIGITS(3), .BLINK_DIV(BD)) dut3 (
        .hwclk(hwclk), .reset(reset), .bus(bus3.slave));

    logic [SW-1:0] score = '0;
    logic          load = 1'b0;
    logic [1:0]    mode = 2'b00;

    assign bus2.score_in = score;
    assign bus2.load     = load;
    assign bus2.mode     = mode;
    assign bus3.score_in = score;
    assign bus3.load     = load;
    assign bus3.mode     = mode;

    typedef struct {
        int unsigned pc;
        bit          ph;
        int unsigned sc;
        int unsigned busy_cnt;
        int unsigned disp_cnt;
        int unsigned pend;
        int unsigned disp;
        bit          ovf;
        logic [63:0] seg;
    } mdl_t;

    mdl_t m[2];

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned v = 1;
        for (int unsigned i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

    function automatic logic [7:0] glyph(input int unsigned d);
        logic [7:0] tab[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        return tab[d];
    endfunction

    function automatic logic [63:0] exp_seg(input int unsigned val, input int unsigned nd,
                                            input logic [1:0] md, input bit ph,
                                            input int unsigned sc);
        logic [63:0] r = '0;
        logic [7:0]  s;
        for (int unsigned k = 0; k < nd; k++) begin
            s = glyph((val / pow10(k)) % 10);
            if (LZ && k > 0 && val < pow10(k)) s = 8'h00;
            if (md == 2'b01 && !ph) s = 8'h00;
            if (md == 2'b10 && k != sc) s = 8'h00;
            if (md == 2'b11) s = 8'h00;
            r[8*k +: 8] = s;
        end
        return r;
    endfunction

    // Advance model instance i by one clock edge using the inputs presented at that edge.
    task automatic model_edge(input int i, input int unsigned nd);
        bit          wrap;
        int unsigned busy_before;
        int unsigned maxv;
        if (!reset) begin
            m[i].pc = 0; m[i].ph = 0; m[i].sc = 0; m[i].busy_cnt = 0;
            m[i].disp_cnt = 0; m[i].pend = 0; m[i].disp = 0; m[i].ovf = 0;
            m[i].seg = '0;
        end else begin
            wrap = (m[i].pc == BD - 1);
            m[i].pc = wrap ? 0 : m[i].pc + 1;
            if (wrap) m[i].ph = !m[i].ph;
            if (mode != 2'b10) m[i].sc = 0;
            else if (wrap) m[i].sc = (m[i].sc + 1) % nd;
            busy_before = m[i].busy_cnt;
            if (m[i].busy_cnt > 0) m[i].busy_cnt--;
            if (m[i].disp_cnt > 0) begin
                m[i].disp_cnt--;
                if (m[i].disp_cnt == 0) m[i].disp = m[i].pend;
            end
            if (load && busy_before == 0) begin
                maxv = pow10(nd) - 1;
                m[i].ovf = (int'(score) > maxv);
                m[i].pend = m[i].ovf ? maxv : int'(score);
                m[i].busy_cnt = SW + 1;
                m[i].disp_cnt = SW + 2;
            end
            m[i].seg = exp_seg(m[i].disp, nd, mode, m[i].ph, m[i].sc);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        model_edge(0, 2);
        model_edge(1, 3);
        @(posedge hwclk);
        #1;
        check("busy2",  64'(bus2.busy),        64'(m[0].busy_cnt > 0));
        check("ovf2",   64'(bus2.overflow),    64'(m[0].ovf));
        check("phase2", 64'(bus2.blink_phase), 64'(m[0].ph));
        check("seg2",   64'(bus2.seg_out),     m[0].seg);
        check("busy3",  64'(bus3.busy),        64'(m[1].busy_cnt > 0));
        check("ovf3",   64'(bus3.overflow),    64'(m[1].ovf));
        check("phase3", 64'(bus3.blink_phase), 64'(m[1].ph));
        check("seg3",   64'(bus3.seg_out),     m[1].seg);
    endtask

    task automatic do_load(input int unsigned v, input int unsigned wait_cycles);
        score = SW'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (wait_cycles) tick();
    endtask

    initial begin
        logic [23:0] scan_pat[3];
        scan_pat[0] = 24'h00004F;
        scan_pat[1] = 24'h005B00;
        scan_pat[2] = 24'h060000;
        for (int i = 0; i < 2; i++) begin
            m[i].pc = 0; m[i].ph = 0; m[i].sc = 0; m[i].busy_cnt = 0;
            m[i].disp_cnt = 0; m[i].pend = 0; m[i].disp = 0; m[i].ovf = 0;
            m[i].seg = '0;
        end

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_seg",   64'(bus2.seg_out), 64'h0);
        check("rst_busy",  64'(bus2.busy), 64'h0);
        check("rst_phase", 64'(bus2.blink_phase), 64'h0);
        reset = 1'b1;

        // Conversion of 42: busy exactly SCORE_W+1 cycles, result at +SCORE_W+2
        mode  = 2'b00;
        score = SW'(42);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("conv_busy_first", 64'(bus2.busy), 64'h1);
        repeat (7) tick();
        check("conv_busy_last", 64'(bus2.busy), 64'h1);
        tick();
        check("conv_busy_drop", 64'(bus2.busy), 64'h0);
        check("conv_seg_hold", 64'(bus2.seg_out), LZ ? 64'h0000_003F : 64'h0000_3F3F);
        tick();
        check("conv_seg_42", 64'(bus2.seg_out), 64'h665B);
        check("conv_ovf",    64'(bus2.overflow), 64'h0);

        // Saturation then recovery
        do_load(127, 10);
        check("sat_seg", 64'(bus2.seg_out), 64'h6F6F);
        check("sat_ovf", 64'(bus2.overflow), 64'h1);
        do_load(5, 10);
        check("unsat_ovf", 64'(bus2.overflow), 64'h0);
        check("unsat_seg", 64'(bus2.seg_out), LZ ? 64'h006D : 64'h3F6D);

        // Busy lockout: second load two cycles later ignored
        do_load(12, 1);
        do_load(77, 10);
        check("lockout_seg", 64'(bus2.seg_out), 64'h065B);

        // Blink follows blink_phase
        do_load(42, 10);
        mode = 2'b01;
        for (int c = 0; c < 16; c++) begin
            tick();
            check("blink_seg", 64'(bus2.seg_out), bus2.blink_phase ? 64'h665B : 64'h0);
        end

        // Scan on the 3-digit instance
        mode = 2'b00;
        do_load(123, 10);
        mode = 2'b10;
        for (int c = 0; c < 24; c++) begin
            tick();
            check("scan_seg3", 64'(bus3.seg_out), 64'(scan_pat[m[1].sc]));
        end

        // Blank mode
        mode = 2'b11;
        tick();
        check("blank_seg", 64'(bus2.seg_out), 64'h0);

        // Reset in the middle of a conversion aborts it
        mode = 2'b00;
        do_load(99, 3);
        reset = 1'b0;
        repeat (3) tick();
        check("midrst_busy", 64'(bus2.busy), 64'h0);
        check("midrst_ovf",  64'(bus2.overflow), 64'h0);
        check("midrst_seg",  64'(bus2.seg_out), 64'h0);
        check("midrst_ph",   64'(bus2.blink_phase), 64'h0);
        reset = 1'b1;
        repeat (12) tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            load  = ($urandom_range(0, 3) == 0);
            score = SW'($urandom_range(0, 127));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1;
        load  = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
